ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: the sending end of the keyboard link whose receive side decodes scan codes into ASCII. It accepts one command byte per handshake (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) and performs the full request-to-send sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop, device ACK. Pin drive is open-drain through output-enable signals. The top level shares PS2_KBCLK/PS2_KBDAT between this block and the receiver.

## Interface
- INHIBIT_CYCLES, 5000: cycles the clock line is held low before the start bit (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles between device clock falling edges before abort (15 ms at 50 MHz).
- CLOCK_50  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- tx_data  in  8  command byte, sampled on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  block idle, can accept a byte.
- tx_done  out  1  one-cycle pulse, frame ACKed by device.
- tx_error  out  1  one-cycle pulse, frame failed (no ACK or timeout).
- ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous).
- ps2_dat_in  in  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive clock pin low; 0 = release.
- ps2_dat_oe  out  1  1 = drive data pin low; 0 = release.

## Operation
- ps2_clk_in/ps2_dat_in pass through 2-flop synchronizers; `fall` = registered synced clock 1→0.
- Accept: tx_valid && tx_ready at a clock edge. Latch tx_data; parity = ~^tx_data (odd parity). tx_valid while tx_ready=0 is ignored, never queued.
- States:
  - IDLE: both oe=0, tx_ready=1. Accept → INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles → RTS.
  - RTS: clk_oe=1, dat_oe=1 (start bit 0) for one cycle → SHIFT with bit index 0, timeout counter cleared.
  - SHIFT: clk_oe=0. On each `fall`: index 0–7 drives data bit i, index 8 drives parity, index 9 releases data (stop, dat_oe=0); index increments. Bit value 1 → dat_oe=0, 0 → dat_oe=1. After the index-9 fall → ACK.
  - ACK: on next `fall`, sample synced data: 0 → tx_done pulse; 1 → tx_error pulse. Either way → WAIT_IDLE.
  - WAIT_IDLE: both oe=0; when synced clock and data are both 1 → IDLE.
- Timeout: in SHIFT and ACK, counter clears on each `fall`, else increments; reaching TIMEOUT_CYCLES → oe both 0, tx_error pulse, → IDLE directly.
- tx_done and tx_error never assert in the same cycle; exactly one per accepted byte, except when reset intervenes.
- Reset (any state, incl. mid-frame): next cycle state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, tx_done=0, tx_error=0, counters 0. No pulse for an aborted frame.

## Timing
- All outputs registered. Reset values: tx_ready=1, all others 0.
- Accept at edge T: tx_ready=0 and ps2_clk_oe=1 from T+1. clk_oe stays high INHIBIT_CYCLES+1 cycles (INHIBIT+RTS); dat_oe rises in the last of them.
- Pin falling edge → `fall` within 3 cycles; dat_oe updates the cycle after `fall`. This is well inside a PS/2 half-period (≥30 µs).
- tx_done/tx_error: the cycle after the ACK `fall`. tx_ready returns the cycle after both lines read high.
- Timeout pulse: TIMEOUT_CYCLES cycles after the last `fall` (or after entering SHIFT).

## Test plan
- Device model clocks a frame at 12.5 kHz and pulls ACK low; send 0xED → dat_oe sequence after start: 0,1,0,0,1,0,0,0 (bits 1,0,1,1,0,1,1,1), parity bit 1 (dat_oe=0), stop released; tx_done one pulse; tx_ready back high.
- Send 0x01 → parity bit 0 (dat_oe=1 at index 8); send 0x00 → parity 1; both tx_done.
- Model clocks all 11 edges but leaves data high at ACK → tx_error one pulse, no tx_done.
- Model never clocks after RTS → tx_error exactly TIMEOUT_CYCLES cycles after entering SHIFT, both oe=0, tx_ready=1.
- Second tx_valid during a frame → ignored; only the first byte is transmitted; one tx_done.
- resetn low at data index 4 → next cycle both oe=0, tx_ready=1, no done/error pulse; a new 0xF4 afterwards completes normally with tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with open-drain pin control
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t      state;
  logic [1:0]  clk_s, dat_s;
  logic        clk_q, fall, timeout;
  logic [9:0]  frame;
  logic [3:0]  idx;
  logic [31:0] cnt;
  assign timeout = cnt == TIMEOUT_CYCLES - 1;
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_q <= 1'b1;
      fall  <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk_in};
      dat_s <= {dat_s[0], ps2_dat_in};
      clk_q <= clk_s[1];
      fall  <= clk_q & ~clk_s[1];
    end
  end
  // frame holds {stop, parity, data}; a 1 bit releases the line, a 0 bit pulls it low
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      frame      <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: if (tx_valid) begin
          frame      <= {1'b1, ~^tx_data, tx_data};
          cnt        <= '0;
          ps2_clk_oe <= 1'b1;
          tx_ready   <= 1'b0;
          state      <= INHIBIT;
        end
        INHIBIT: if (cnt == INHIBIT_CYCLES - 1) begin
          ps2_dat_oe <= 1'b1;
          state      <= RTS;
        end else cnt <= cnt + 32'd1;
        RTS: begin
          ps2_clk_oe <= 1'b0;
          cnt        <= '0;
          idx        <= '0;
          state      <= SHIFT;
        end
        SHIFT, ACK: if (fall) begin
          cnt <= '0;
          if (state == ACK) begin
            tx_done  <= ~dat_s[1];
            tx_error <= dat_s[1];
            state    <= WAIT_IDLE;
          end else begin
            ps2_dat_oe <= ~frame[idx];
            idx        <= idx + 4'd1;
            state      <= idx == 4'd9 ? ACK : SHIFT;
          end
        end else if (timeout) begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_error   <= 1'b1;
          tx_ready   <= 1'b1;
          state      <= IDLE;
        end else cnt <= cnt + 32'd1;
        WAIT_IDLE: begin
          ps2_dat_oe <= 1'b0;
          if (clk_s[1] && dat_s[1]) begin
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed frames against a PS/2 device model, scoreboard-checked
module tb_ps2_host_tx;
  localparam int N = 20, TO = 200, H = 20;
  logic clk = 0, resetn = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, tx_done, tx_error, clk_oe, dat_oe;
  logic dev_clk_low = 0, dev_dat_low = 0;
  logic clk_line, dat_line;
  logic [9:0] obs_bits = 0;
  typedef struct packed {logic ok; logic chk; logic [9:0] bits;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  assign clk_line = ~(clk_oe | dev_clk_low);
  assign dat_line = ~(dat_oe | dev_dat_low);
  ps2_host_tx #(.INHIBIT_CYCLES(N), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(clk), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(clk_line), .ps2_dat_in(dat_line),
    .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (tx_done || tx_error) begin
      chk("exclusive", {31'd0, tx_done & tx_error}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b error=%0b with nothing pending", tx_done, tx_error);
      end else begin
        e = exp_q.pop_front();
        chk("result_done", {31'd0, tx_done}, {31'd0, e.ok});
        if (e.chk) chk("frame_bits", {22'd0, obs_bits}, {22'd0, e.bits});
      end
    end
  end
  task automatic send(input logic [7:0] d, input logic ok, input logic c, input logic [9:0] b);
    @(negedge clk);
    chk("ready_before", {31'd0, tx_ready}, 1);
    tx_data = d;
    tx_valid = 1;
    exp_q.push_back({ok, c, b});
    @(negedge clk);
    tx_valid = 0;
    chk("accept_ready", {31'd0, tx_ready}, 0);
    chk("accept_clk_oe", {31'd0, clk_oe}, 1);
  endtask
  task automatic dev_frame(input logic ack, input int abort_after);
    int hi = 1, df = 0;
    while (1) begin
      @(negedge clk);
      if (!clk_oe || hi > 1000) break;
      hi++;
      if (dat_oe && df == 0) df = hi;
    end
    chk("inhibit_len", hi, N + 1);
    chk("rts_cycle", df, N + 1);
    chk("start_bit", {31'd0, dat_oe}, 1);
    for (int i = 0; i < 11; i++) begin
      repeat (H) @(negedge clk);
      if (i == 10 && ack) dev_dat_low = 1;
      dev_clk_low = 1;
      repeat (H) @(negedge clk);
      if (i < 10) obs_bits[i] = dat_line;
      if (i + 1 == abort_after) begin
        dev_clk_low = 0;
        resetn = 0;
        @(negedge clk);
        chk("rst_clk_oe", {31'd0, clk_oe}, 0);
        chk("rst_dat_oe", {31'd0, dat_oe}, 0);
        chk("rst_ready", {31'd0, tx_ready}, 1);
        chk("rst_done", {31'd0, tx_done}, 0);
        chk("rst_error", {31'd0, tx_error}, 0);
        resetn = 1;
        exp_q.delete();
        return;
      end
      dev_clk_low = 0;
    end
    repeat (H) @(negedge clk);
    dev_dat_low = 0;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_return", {31'd0, tx_ready}, 1);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, tx_ready}, 1);
    chk("reset_clk_oe", {31'd0, clk_oe}, 0);
    chk("reset_dat_oe", {31'd0, dat_oe}, 0);
    chk("reset_pulses", {30'd0, tx_done, tx_error}, 0);
    resetn = 1;
    send(8'hED, 1, 1, 10'h3ED);
    dev_frame(1, 0);
    wait_ready();
    send(8'h01, 1, 1, 10'h201);
    tx_data = 8'h55;
    tx_valid = 1;
    dev_frame(1, 0);
    tx_valid = 0;
    wait_ready();
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (clk_oe) n++;
    end
    chk("no_second_frame", n, 0);
    send(8'h00, 1, 1, 10'h300);
    dev_frame(1, 0);
    wait_ready();
    send(8'h5A, 0, 1, 10'h35A);
    dev_frame(0, 0);
    wait_ready();
    send(8'hAA, 0, 0, 10'h000);
    n = 0;
    while (clk_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_clk_oe", {31'd0, clk_oe}, 0);
    chk("timeout_dat_oe", {31'd0, dat_oe}, 0);
    chk("timeout_ready", {31'd0, tx_ready}, 1);
    send(8'hED, 1, 1, 10'h3ED);
    dev_frame(1, 5);
    repeat (10) @(negedge clk);
    chk("abort_idle_clk_oe", {31'd0, clk_oe}, 0);
    send(8'hF4, 1, 1, 10'h2F4);
    dev_frame(1, 0);
    wait_ready();
    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
